mem_arbiter: RTL

Two-port arbiter and sequencer for the single-ported word memory (`Memory`: `CS`, `WE`, `CLK`, `ADDR`, bidirectional `Mem_Bus`, falling-edge access).
- It shares that memory between the instruction-fetch port (read-only) and the data load/store port (read/write).
- It drives the memory control lines and owns the write direction of `Mem_Bus`.
- It returns read data and completion to the winning requester one cycle after acceptance.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_arb_prio.sv | 40 ++++
 rtl/mem_arbiter.sv | 115 +++++++++++
 3 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the two-port memory arbiter.
package mem_arb_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        ACCESS = 1'b1
    } state_t;

    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    localparam int MEM_WORDS_DEF = 128;

endpackage

// File: rtl/mem_arb_prio.sv
// Grant selection between fetch and data ports.
// Build option MEM_ARB_RR_EN: round-robin on contention, else data port always wins.
module mem_arb_prio
    import mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic idle,
    input  logic i_valid,
    input  logic d_valid,
    output logic i_gnt,
    output logic d_gnt
);

    logic d_win;

`ifdef MEM_ARB_RR_EN
    // Port served most recently; reset value lets the data port win first.
    logic last_port;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            last_port <= PORT_I;
        else if (d_gnt)
            last_port <= PORT_D;
        else if (i_gnt)
            last_port <= PORT_I;
    end

    assign d_win = d_valid && (!i_valid || last_port == PORT_I);
`else
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign d_win = d_valid;
`endif

    assign d_gnt = idle && d_win;
    assign i_gnt = idle && i_valid && !d_win;

endmodule

// File: rtl/mem_arbiter.sv
// Shares a single-ported falling-edge word memory between fetch and data ports.
// Build option MEM_ARB_RR_EN selects round-robin arbitration (see mem_arb_prio).
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W    = 32,
    parameter int ADDR_W    = 32,
    parameter int MEM_WORDS = MEM_WORDS_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              i_valid,
    input  logic [ADDR_W-1:0] i_addr,
    output logic              i_gnt,
    output logic              i_rvalid,
    output logic [DATA_W-1:0] i_rdata,
    output logic              i_err,
    input  logic              d_valid,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_gnt,
    output logic              d_rvalid,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_err,
    output logic              CS,
    output logic              WE,
    output logic [ADDR_W-1:0] ADDR,
    inout  wire  [DATA_W-1:0] Mem_Bus
);

    state_t            state, state_nx;
    logic              lat_port, lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              in_range, acc;
    logic [DATA_W-1:0] rd_val;

    mem_arb_prio u_prio (
        .clk     (CLK),
        .rst     (RST),
        .idle    (state == IDLE),
        .i_valid (i_valid),
        .d_valid (d_valid),
        .i_gnt   (i_gnt),
        .d_gnt   (d_gnt)
    );

    assign acc      = (state == ACCESS);
    assign in_range = lat_addr < ADDR_W'(MEM_WORDS);
    assign rd_val   = (in_range && !lat_we) ? Mem_Bus : '0;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        CS       = 1'b0;
        WE       = 1'b0;
        ADDR     = '0;
        case (state)
            IDLE: begin
                if (i_gnt || d_gnt) state_nx = ACCESS;
            end
            ACCESS: begin
                state_nx = IDLE;
                ADDR     = lat_addr;
                CS       = in_range;
                WE       = in_range && lat_we;
            end
        endcase
    end

    // WE is only ever high together with CS, so loads never see us on the bus.
    assign Mem_Bus = WE ? lat_wdata : 'z;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            lat_port  <= PORT_I;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
        end else if (i_gnt || d_gnt) begin
            lat_port  <= d_gnt ? PORT_D : PORT_I;
            lat_we    <= d_gnt && d_we;
            lat_addr  <= d_gnt ? d_addr : i_addr;
            lat_wdata <= d_wdata;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            i_rvalid <= 1'b0;
            i_rdata  <= '0;
            i_err    <= 1'b0;
            d_rvalid <= 1'b0;
            d_rdata  <= '0;
            d_err    <= 1'b0;
        end else begin
            i_rvalid <= acc && lat_port == PORT_I;
            d_rvalid <= acc && lat_port == PORT_D;
            if (acc && lat_port == PORT_I) begin
                i_rdata <= rd_val;
                i_err   <= !in_range;
            end
            if (acc && lat_port == PORT_D) begin
                d_rdata <= rd_val;
                d_err   <= !in_range;
            end
        end
    end

endmodule
